// File: rtl/photonic_tx_scheduler.sv
// Round-robin arbiter and frame serialiser for a shared photonic transmitter.
// Frame = START(1) + ID(ID_W) + DATA(DATA_W), MSB first, followed by GAP idle cycles.
module photonic_tx_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int GAP     = 2
) (
  input  logic                      clk,
  input  logic                      n_reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic                      tx_bit,
  output logic                      tx_ctrl,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int SH_W    = ID_W + DATA_W;
  localparam int CNT_MAX = (ID_W > DATA_W) ? ((ID_W > GAP) ? ID_W : GAP)
                                           : ((DATA_W > GAP) ? DATA_W : GAP);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ID,
    S_DATA,
    S_GAP
  } state_t;

  state_t              r_state, w_state;
  logic [CNT_W-1:0]    r_cnt, w_cnt;
  logic [SH_W-1:0]     r_sh, w_sh;
  logic [ID_W-1:0]     r_rr, w_rr;
  logic [NUM_REQ-1:0]  r_ack, w_ack;
  logic                r_bit, w_bit;
  logic                r_ctrl, w_ctrl;
  logic                r_busy, w_busy;
  logic                r_done, w_done;

  logic                w_found;
  logic [ID_W-1:0]     w_g;
  logic [ID_W-1:0]     w_idx;
  logic [DATA_W-1:0]   w_words [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_words
    assign w_words[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  // ID and payload share one shift register so the serial bit is always its MSB.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_sh    = r_sh;
    w_rr    = r_rr;
    w_ack   = '0;
    w_bit   = 1'b0;
    w_ctrl  = 1'b0;
    w_done  = 1'b0;
    w_found = 1'b0;
    w_g     = '0;
    w_idx   = '0;

    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_idx = ID_W'((32'(r_rr) + i) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_g     = w_idx;
      end
    end

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state      = S_START;
          w_cnt        = '0;
          w_sh         = {w_g, w_words[w_g]};
          w_rr         = (32'(w_g) == NUM_REQ - 1) ? '0 : w_g + 1'b1;
          w_ack[w_g]   = 1'b1;
          w_bit        = 1'b1;
          w_ctrl       = 1'b1;
        end
      end
      S_START: begin
        w_state = S_ID;
        w_cnt   = '0;
        w_bit   = r_sh[SH_W-1];
        w_sh    = r_sh << 1;
        w_ctrl  = 1'b1;
      end
      S_ID: begin
        w_bit  = r_sh[SH_W-1];
        w_sh   = r_sh << 1;
        w_ctrl = 1'b1;
        if (r_cnt == CNT_W'(ID_W - 1)) begin
          w_state = S_DATA;
          w_cnt   = '0;
          w_done  = (DATA_W == 1);
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (r_cnt == CNT_W'(DATA_W - 1)) begin
          w_state = S_GAP;
          w_cnt   = '0;
        end else begin
          w_cnt  = r_cnt + 1'b1;
          w_bit  = r_sh[SH_W-1];
          w_sh   = r_sh << 1;
          w_ctrl = 1'b1;
          w_done = (r_cnt == CNT_W'(DATA_W - 2));
        end
      end
      S_GAP: begin
        if (r_cnt == CNT_W'(GAP - 1)) begin
          w_state = S_IDLE;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_cnt   = '0;
      end
    endcase

    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sh    <= '0;
      r_rr    <= '0;
      r_ack   <= '0;
      r_bit   <= 1'b0;
      r_ctrl  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_sh    <= w_sh;
      r_rr    <= w_rr;
      r_ack   <= w_ack;
      r_bit   <= w_bit;
      r_ctrl  <= w_ctrl;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  assign req_ack    = r_ack;
  assign tx_bit     = r_bit;
  assign tx_ctrl    = r_ctrl;
  assign busy       = r_busy;
  assign frame_done = r_done;

endmodule

// File: tb/tb_photonic_tx_scheduler.sv
// Directed bench for photonic_tx_scheduler: table of single frames plus reset and spacing sequences.
module tb_photonic_tx_scheduler;

  localparam logic [63:0] DATA0 = {16'hFFFF, 16'hA5C3, 16'h5A0F, 16'h8001};

  logic        clk;
  logic        n_reset;
  logic [3:0]  a_valid, b_valid;
  logic [63:0] req_data;
  logic [3:0]  a_ack, b_ack;
  logic        a_tx_bit, a_tx_ctrl, a_busy, a_done;
  logic        b_tx_bit, b_tx_ctrl, b_busy, b_done;

  int n_cmp = 0;
  int n_bad = 0;

  photonic_tx_scheduler #(.NUM_REQ(4), .DATA_W(16), .GAP(2)) dut_a (
    .clk        (clk),
    .n_reset    (n_reset),
    .req_valid  (a_valid),
    .req_data   (req_data),
    .req_ack    (a_ack),
    .tx_bit     (a_tx_bit),
    .tx_ctrl    (a_tx_ctrl),
    .busy       (a_busy),
    .frame_done (a_done)
  );

  photonic_tx_scheduler #(.NUM_REQ(4), .DATA_W(16), .GAP(1)) dut_b (
    .clk        (clk),
    .n_reset    (n_reset),
    .req_valid  (b_valid),
    .req_data   (req_data),
    .req_ack    (b_ack),
    .tx_bit     (b_tx_bit),
    .tx_ctrl    (b_tx_ctrl),
    .busy       (b_busy),
    .frame_done (b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  va;
    int          g;
    logic [15:0] w;
    int          chg;
    string       nm;
  } rec_t;

  rec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Request at an IDLE negedge; follows the frame through START, ID, DATA, GAP and the IDLE cycle.
  task automatic run_frame(input logic [3:0] v, input logic [3:0] va, input int g,
                           input logic [15:0] w, input int chg, input string nm);
    int t;
    int done_cnt, done_at, ctrl_cnt, ack_cnt, busy_bad, gap_bad;
    logic [17:0] bits;
    req_data = DATA0;
    a_valid  = v;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!a_tx_ctrl && t < 40);
    chk({nm, "_latency"}, t, 1);
    chk({nm, "_ack"}, 32'(a_ack), 32'(4'b0001 << g));
    chk({nm, "_start_bit"}, 32'(a_tx_bit), 1);
    chk({nm, "_start_busy"}, 32'(a_busy), 1);
    a_valid  = va;
    bits     = '0;
    done_cnt = 0; done_at = -1; ctrl_cnt = 0; ack_cnt = 0; busy_bad = 0; gap_bad = 0;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      bits = {bits[16:0], a_tx_bit};
      if (a_done) begin done_cnt++; done_at = k; end
      if (a_tx_ctrl) ctrl_cnt++;
      if (a_ack != 4'b0000) ack_cnt++;
      if (!a_busy) busy_bad++;
      if (k == chg) begin
        a_valid  = 4'b0000;
        req_data = ~DATA0;
      end
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (a_tx_ctrl || a_tx_bit || !a_busy || a_done) gap_bad++;
    end
    @(negedge clk);
    chk({nm, "_id"}, 32'(bits[17:16]), 32'(g));
    chk({nm, "_payload"}, 32'(bits[15:0]), 32'(w));
    chk({nm, "_ctrl_cycles"}, ctrl_cnt, 18);
    chk({nm, "_done_count"}, done_cnt, 1);
    chk({nm, "_done_pos"}, done_at, 17);
    chk({nm, "_ack_extra"}, ack_cnt, 0);
    chk({nm, "_busy_drop"}, busy_bad, 0);
    chk({nm, "_gap"}, gap_bad, 0);
    chk({nm, "_idle_busy"}, 32'(a_busy), 0);
    chk({nm, "_idle_ctrl"}, 32'(a_tx_ctrl), 0);
  endtask

  initial begin
    int t;
    int n_st, prev;
    int st [3];

    n_reset  = 1'b0;
    a_valid  = '0;
    b_valid  = '0;
    req_data = DATA0;

    tbl[0]  = '{4'b0100, 4'b0000, 2, 16'hA5C3, -1, "single_r2"};
    tbl[1]  = '{4'b1000, 4'b0000, 3, 16'hFFFF, -1, "single_r3"};
    tbl[2]  = '{4'b1111, 4'b1111, 0, 16'h8001, -1, "rr_0"};
    tbl[3]  = '{4'b1111, 4'b1111, 1, 16'h5A0F, -1, "rr_1"};
    tbl[4]  = '{4'b1111, 4'b1111, 2, 16'hA5C3, -1, "rr_2"};
    tbl[5]  = '{4'b1111, 4'b1111, 3, 16'hFFFF, -1, "rr_3"};
    tbl[6]  = '{4'b1111, 4'b1111, 0, 16'h8001, -1, "rr_4"};
    tbl[7]  = '{4'b0010, 4'b0010, 1, 16'h5A0F,  7, "drop_mid"};
    tbl[8]  = '{4'b0011, 4'b0000, 0, 16'h8001, -1, "wrap_r0"};
    tbl[9]  = '{4'b0101, 4'b0000, 2, 16'hA5C3, -1, "skip_r2"};
    tbl[10] = '{4'b0110, 4'b0000, 1, 16'h5A0F, -1, "wrap_r1"};

    // Held in reset while inputs toggle.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_ack", 32'(a_ack), 0);
      chk("rst_ctrl", 32'(a_tx_ctrl), 0);
      chk("rst_bit", 32'(a_tx_bit), 0);
      chk("rst_busy", 32'(a_busy | b_busy | b_tx_ctrl), 0);
      a_valid  = 4'($urandom);
      b_valid  = 4'($urandom);
      req_data = {$urandom, $urandom};
    end
    a_valid  = '0;
    b_valid  = '0;
    req_data = DATA0;
    @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(a_busy), 0);

    for (int r = 0; r < 11; r++)
      run_frame(tbl[r].v, tbl[r].va, tbl[r].g, tbl[r].w, tbl[r].chg, tbl[r].nm);

    // Reset in the 8th DATA cycle, then recover with rr_ptr back at 0.
    req_data = DATA0;
    a_valid  = 4'b0100;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!a_tx_ctrl && t < 40);
    chk("midrst_ack", 32'(a_ack), 32'(4'b0100));
    a_valid = 4'b0000;
    repeat (10) @(negedge clk);
    chk("midrst_pre_ctrl", 32'(a_tx_ctrl), 1);
    n_reset = 1'b0;
    #1;
    chk("midrst_ctrl", 32'(a_tx_ctrl), 0);
    chk("midrst_busy", 32'(a_busy), 0);
    chk("midrst_bit", 32'(a_tx_bit), 0);
    chk("midrst_ack0", 32'(a_ack), 0);
    @(negedge clk);
    chk("midrst_hold_ctrl", 32'(a_tx_ctrl), 0);
    n_reset = 1'b1;
    run_frame(4'b1001, 4'b0000, 0, 16'h8001, -1, "rst_recover");

    // GAP=1 instance with one requester held: START-to-START spacing.
    b_valid = 4'b1000;
    n_st = 0;
    prev = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (b_tx_ctrl && prev == 0 && n_st < 3) begin
        st[n_st] = c;
        n_st++;
      end
      prev = int'(b_tx_ctrl);
    end
    chk("gap1_starts", n_st, 3);
    if (n_st == 3) begin
      chk("gap1_space_a", st[1] - st[0], 21);
      chk("gap1_space_b", st[2] - st[1], 21);
    end
    b_valid = 4'b0000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
